// File: rtl/bp_be_acc_pkg.sv
// Shared types for the BE accelerator op scheduler: op encodings and FSM states.
// Activation loads (op[1]==0) advance the destination address; weight loads do not.
package bp_be_acc_pkg;

    typedef enum logic [1:0] {
        ACLD0 = 2'b00,
        ACLD1 = 2'b01,
        WTLD0 = 2'b10,
        WTLD1 = 2'b11
    } bp_be_acc_op_e;

    typedef enum logic [1:0] {
        eIDLE      = 2'b00,
        eWAIT_DATA = 2'b01,
        eISSUE     = 2'b10,
        eBUSY      = 2'b11
    } bp_be_acc_sched_state_e;

    function automatic logic is_act_op(input bp_be_acc_op_e op);
        return ~op[1];
    endfunction

endpackage

// File: rtl/bp_be_acc_sched_fifo.sv
// 1r1w FIFO with full/empty and an overflow pulse for a dropped enqueue.
// Enqueue while full is accepted only when a dequeue happens in the same cycle.
module bp_be_acc_sched_fifo
    import bp_be_acc_pkg::*;
#(
    parameter int width_p = 2,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    input  logic               yumi_i,
    output logic [width_p-1:0] data_o,
    output logic               full_o,
    output logic               empty_o,
    output logic               overflow_o
);

    localparam int              ptr_w_lp = $clog2(els_p);
    localparam logic [ptr_w_lp:0] one_lp = 1;

    logic [width_p-1:0] mem_q [els_p];
    logic [ptr_w_lp:0]  wptr_q, rptr_q;
    logic               enq, deq;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o    = (wptr_q == rptr_q);
    assign full_o     = (wptr_q[ptr_w_lp] != rptr_q[ptr_w_lp])
                     && (wptr_q[ptr_w_lp-1:0] == rptr_q[ptr_w_lp-1:0]);
    assign deq        = yumi_i & ~empty_o;
    assign enq        = v_i & (~full_o | deq);
    assign overflow_o = v_i & full_o & ~deq;
    assign data_o     = mem_q[rptr_q[ptr_w_lp-1:0]];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (enq) wptr_q <= wptr_q + one_lp;
            if (deq) rptr_q <= rptr_q + one_lp;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wptr_q[ptr_w_lp-1:0]] <= data_i;
    end

endmodule

// File: rtl/bp_be_acc_op_sched.sv
// Pairs committed tensor-load ops with wide D$ fill data and issues them one at a time to the DPU.
// Optional perf counters under BP_BE_ACC_SCHED_PERF_EN; issue is valid-then-ready, wide data cannot be stalled.
module bp_be_acc_op_sched
    import bp_be_acc_pkg::*;
#(
    parameter int block_width_p = 512,
    parameter int addr_width_p  = 64,
    parameter int els_p         = 2,
    parameter int stride_p      = 64
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [1:0]               op_i,
    input  logic                     op_v_i,
    input  logic [block_width_p-1:0] wide_data_i,
    input  logic                     wide_v_i,
    input  logic [addr_width_p-1:0]  dest_base_i,
    input  logic                     dest_v_i,
    output logic [1:0]               dpu_op_o,
    output logic [block_width_p-1:0] dpu_data_o,
    output logic [addr_width_p-1:0]  dpu_addr_o,
    output logic                     dpu_v_o,
    input  logic                     dpu_ready_and_i,
    input  logic                     dpu_done_i,
    output logic                     busy_o,
    output logic                     panic_o
`ifdef BP_BE_ACC_SCHED_PERF_EN
    ,
    output logic [63:0]              perf_wait_data_o,
    output logic [63:0]              perf_wait_dpu_o
`endif
);

    bp_be_acc_sched_state_e   state_q, state_d;
    bp_be_acc_op_e            busy_op_q;
    logic [addr_width_p-1:0]  addr_q, addr_d;
    logic                     panic_q;

    logic                     op_full, op_empty, op_ovf;
    logic                     data_full, data_empty, data_ovf;
    logic [1:0]               op_head;
    logic [block_width_p-1:0] data_head;
    logic                     data_v, issue_hs, in_issue, act_done;
    logic                     op_avail, data_avail;

    assign data_v   = wide_v_i & ~panic_q;
    assign in_issue = (state_q == eISSUE);
    assign issue_hs = in_issue & dpu_ready_and_i;

    bp_be_acc_sched_fifo #(.width_p(2), .els_p(els_p)) op_fifo (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .data_i     (op_i),
        .v_i        (op_v_i),
        .yumi_i     (issue_hs),
        .data_o     (op_head),
        .full_o     (op_full),
        .empty_o    (op_empty),
        .overflow_o (op_ovf)
    );

    bp_be_acc_sched_fifo #(.width_p(block_width_p), .els_p(els_p)) data_fifo (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .data_i     (wide_data_i),
        .v_i        (data_v),
        .yumi_i     (issue_hs),
        .data_o     (data_head),
        .full_o     (data_full),
        .empty_o    (data_empty),
        .overflow_o (data_ovf)
    );

    // Count this cycle's enqueue as available so issue follows the later arrival by one cycle.
    assign op_avail   = ~op_empty | op_v_i;
    assign data_avail = ~data_empty | data_v;

    always_comb begin
        state_d = state_q;
        case (state_q)
            eIDLE:      if (op_avail) state_d = data_avail ? eISSUE : eWAIT_DATA;
            eWAIT_DATA: if (data_avail) state_d = eISSUE;
            eISSUE:     if (dpu_ready_and_i) state_d = eBUSY;
            eBUSY:      if (dpu_done_i) state_d = eIDLE;
            default:    state_d = eIDLE;
        endcase
    end

    assign act_done = (state_q == eBUSY) & dpu_done_i & is_act_op(busy_op_q);

    always_comb begin
        addr_d = addr_q;
        if (dest_v_i)      addr_d = dest_base_i;
        else if (act_done) addr_d = addr_q + addr_width_p'(stride_p);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= eIDLE;
            busy_op_q <= ACLD0;
            addr_q    <= '0;
            panic_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            panic_q <= panic_q | op_ovf | data_ovf;
            if (issue_hs) busy_op_q <= bp_be_acc_op_e'(op_head);
        end
    end

    assign dpu_v_o    = in_issue;
    assign dpu_op_o   = in_issue ? op_head   : '0;
    assign dpu_data_o = in_issue ? data_head : '0;
    assign dpu_addr_o = in_issue ? addr_q    : '0;
    assign busy_o     = op_full | data_full | (state_q == eBUSY) | in_issue;
    assign panic_o    = panic_q;

`ifdef BP_BE_ACC_SCHED_PERF_EN
    logic [63:0] perf_wait_data_q, perf_wait_dpu_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            perf_wait_data_q <= '0;
            perf_wait_dpu_q  <= '0;
        end else begin
            if ((state_q == eWAIT_DATA) && ~&perf_wait_data_q)
                perf_wait_data_q <= perf_wait_data_q + 64'd1;
            if (in_issue && !dpu_ready_and_i && ~&perf_wait_dpu_q)
                perf_wait_dpu_q <= perf_wait_dpu_q + 64'd1;
        end
    end

    assign perf_wait_data_o = perf_wait_data_q;
    assign perf_wait_dpu_o  = perf_wait_dpu_q;
`endif

endmodule
